// File: rtl/sha256_pkg.sv
// Shared types for the SHA-256 message-schedule sequencer: ALU opcodes, FSM states
// and the 15-row micro-op ROM that expands one schedule word W[t].
package sha256_pkg;

    localparam int OPS_PER_WORD = 15;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_SRA  = 5'd5;
    localparam logic [4:0] OP_XOR  = 5'd6;
    localparam logic [4:0] OP_ROTR = 5'd7;

    // The ALU only shifts arithmetically; these masks clear the sign-filled bits.
    localparam logic [31:0] MASK_SHR3  = 32'h1FFFFFFF;
    localparam logic [31:0] MASK_SHR10 = 32'h003FFFFF;

    typedef enum logic [1:0] {LOAD, COMPUTE, OUT} state_t;

    typedef enum logic [1:0] {A_W15, A_W2, A_ACC, A_TMP} src_a_t;
    typedef enum logic [2:0] {B_ZERO, B_TMP, B_MASK3, B_MASK10, B_W7, B_S0, B_W16} src_b_t;
    typedef enum logic [1:0] {D_ACC, D_TMP, D_S0, D_W} dest_t;

    typedef struct packed {
        logic [4:0] opcode;
        src_a_t     src_a;
        src_b_t     src_b;
        logic [4:0] shamt;
        dest_t      dest;
    } uop_t;

    function automatic uop_t uop_rom(input logic [3:0] step);
        case (step)
            4'd0:    uop_rom = '{OP_ROTR, A_W15, B_ZERO,   5'd7,  D_ACC};
            4'd1:    uop_rom = '{OP_ROTR, A_W15, B_ZERO,   5'd18, D_TMP};
            4'd2:    uop_rom = '{OP_XOR,  A_ACC, B_TMP,    5'd0,  D_ACC};
            4'd3:    uop_rom = '{OP_SRA,  A_W15, B_ZERO,   5'd3,  D_TMP};
            4'd4:    uop_rom = '{OP_AND,  A_TMP, B_MASK3,  5'd0,  D_TMP};
            4'd5:    uop_rom = '{OP_XOR,  A_ACC, B_TMP,    5'd0,  D_S0};
            4'd6:    uop_rom = '{OP_ROTR, A_W2,  B_ZERO,   5'd17, D_ACC};
            4'd7:    uop_rom = '{OP_ROTR, A_W2,  B_ZERO,   5'd19, D_TMP};
            4'd8:    uop_rom = '{OP_XOR,  A_ACC, B_TMP,    5'd0,  D_ACC};
            4'd9:    uop_rom = '{OP_SRA,  A_W2,  B_ZERO,   5'd10, D_TMP};
            4'd10:   uop_rom = '{OP_AND,  A_TMP, B_MASK10, 5'd0,  D_TMP};
            4'd11:   uop_rom = '{OP_XOR,  A_ACC, B_TMP,    5'd0,  D_ACC};
            4'd12:   uop_rom = '{OP_ADD,  A_ACC, B_W7,     5'd0,  D_ACC};
            4'd13:   uop_rom = '{OP_ADD,  A_ACC, B_S0,     5'd0,  D_ACC};
            4'd14:   uop_rom = '{OP_ADD,  A_ACC, B_W16,    5'd0,  D_W};
            default: uop_rom = '{OP_ADD,  A_ACC, B_ZERO,   5'd0,  D_ACC};
        endcase
    endfunction

endpackage

// File: rtl/sha256_msg_schedule_seq_if.sv
// Upstream load, downstream schedule-word and ALU micro-op signals of the schedule sequencer.
interface sha256_msg_schedule_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [5:0]  out_index;
    logic        busy;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_operandA;
    logic [31:0] alu_operandB;
    logic [4:0]  alu_shiftamt;
    logic [31:0] alu_result;

    modport master (
        output in_ready, out_valid, out_word, out_index, busy,
               alu_opcode, alu_operandA, alu_operandB, alu_shiftamt,
        input  in_valid, in_word, out_ready, alu_result
    );

    modport slave (
        input  in_ready, out_valid, out_word, out_index, busy,
               alu_opcode, alu_operandA, alu_operandB, alu_shiftamt,
        output in_valid, in_word, out_ready, alu_result
    );
endinterface

// File: rtl/sha256_w_buffer.sv
// 16-entry circular schedule buffer; W[t] lives in slot t%16. Three async read ports, one write.
module sha256_w_buffer (
    input  logic        clk,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  ra_2,
    input  logic [3:0]  ra_7,
    input  logic [3:0]  ra_x,
    output logic [31:0] rd_2,
    output logic [31:0] rd_7,
    output logic [31:0] rd_x
);
    logic [15:0][31:0] mem;

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rd_2 = mem[ra_2];
    assign rd_7 = mem[ra_7];
    assign rd_x = mem[ra_x];
endmodule

// File: rtl/sha256_msg_schedule_seq.sv
// Expands a loaded 16-word block into W16..W63 by issuing one ALU micro-op per cycle
// to an external combinational ALU; 15 micro-ops plus one output cycle per word.
module sha256_msg_schedule_seq
    import sha256_pkg::*;
(
    input  logic clk,
    input  logic rst,
    sha256_msg_schedule_seq_if.master bus
);
    state_t      state, state_nx;
    logic [3:0]  load_cnt, step;
    logic [5:0]  t;
    logic [31:0] acc, tmp, s0, out_word_q;
    logic [5:0]  out_index_q;
    logic [31:0] op_a, op_b, rd_2, rd_7, rd_x;
    uop_t        uop;
    logic        in_acc, last_step;

    assign uop       = uop_rom(step);
    assign in_acc    = (state == LOAD) && bus.in_valid;
    assign last_step = (step == 4'(OPS_PER_WORD - 1));

    // Slot offsets mod 16: t-2 = t+14, t-7 = t+9, t-15 = t+1, t-16 = t.
    sha256_w_buffer u_wbuf (
        .clk   (clk),
        .we    (in_acc || (state == COMPUTE && last_step)),
        .waddr ((state == LOAD) ? load_cnt : t[3:0]),
        .wdata ((state == LOAD) ? bus.in_word : bus.alu_result),
        .ra_2  (t[3:0] + 4'd14),
        .ra_7  (t[3:0] + 4'd9),
        .ra_x  ((uop.src_b == B_W16) ? t[3:0] : t[3:0] + 4'd1),
        .rd_2  (rd_2),
        .rd_7  (rd_7),
        .rd_x  (rd_x)
    );

    always_comb begin
        op_a = '0;
        case (uop.src_a)
            A_W15:   op_a = rd_x;
            A_W2:    op_a = rd_2;
            A_ACC:   op_a = acc;
            default: op_a = tmp;
        endcase
        op_b = '0;
        case (uop.src_b)
            B_TMP:    op_b = tmp;
            B_MASK3:  op_b = MASK_SHR3;
            B_MASK10: op_b = MASK_SHR10;
            B_W7:     op_b = rd_7;
            B_S0:     op_b = s0;
            B_W16:    op_b = rd_x;
            default:  op_b = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= LOAD;
        else     state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (in_acc && load_cnt == 4'd15) state_nx = COMPUTE;
            COMPUTE: if (last_step) state_nx = OUT;
            OUT:     if (bus.out_ready) state_nx = (t == 6'd63) ? LOAD : COMPUTE;
            default: state_nx = LOAD;
        endcase
    end

    always_comb begin
        bus.in_ready     = 1'b0;
        bus.out_valid    = 1'b0;
        bus.busy         = 1'b0;
        bus.alu_opcode   = '0;
        bus.alu_operandA = '0;
        bus.alu_operandB = '0;
        bus.alu_shiftamt = '0;
        case (state)
            LOAD: bus.in_ready = 1'b1;
            COMPUTE: begin
                bus.busy         = 1'b1;
                bus.alu_opcode   = uop.opcode;
                bus.alu_operandA = op_a;
                bus.alu_operandB = op_b;
                bus.alu_shiftamt = uop.shamt;
            end
            OUT: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.out_word  = out_word_q;
    assign bus.out_index = out_index_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            load_cnt    <= '0;
            t           <= 6'd16;
            step        <= '0;
            acc         <= '0;
            tmp         <= '0;
            s0          <= '0;
            out_word_q  <= '0;
            out_index_q <= '0;
        end else begin
            case (state)
                LOAD: if (in_acc) begin
                    load_cnt <= load_cnt + 4'd1;
                    if (load_cnt == 4'd15) begin
                        t    <= 6'd16;
                        step <= '0;
                    end
                end
                COMPUTE: begin
                    step <= last_step ? 4'd0 : step + 4'd1;
                    case (uop.dest)
                        D_ACC: acc <= bus.alu_result;
                        D_TMP: tmp <= bus.alu_result;
                        D_S0:  s0  <= bus.alu_result;
                        default: begin
                            out_word_q  <= bus.alu_result;
                            out_index_q <= t;
                        end
                    endcase
                end
                OUT: if (bus.out_ready) begin
                    step <= '0;
                    if (t == 6'd63) begin
                        t        <= 6'd16;
                        load_cnt <= '0;
                    end else begin
                        t <= t + 6'd1;
                    end
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_sha256_msg_schedule_seq.sv
// Scoreboard bench: a reference ALU drives alu_result, a direct sigma model predicts W16..W63.
module tb_sha256_msg_schedule_seq;
    logic clk = 1'b0;
    logic rst;

    sha256_msg_schedule_seq_if bus();

    sha256_msg_schedule_seq dut (.clk(clk), .rst(rst), .bus(bus.master));

    always #5 clk = ~clk;

    typedef struct packed { logic [5:0] idx; logic [31:0] w; } exp_t;
    exp_t        sb[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_hs = 0;
    bit          spacing_en = 1'b0;
    logic [31:0] dut_w [64];
    logic [31:0] blk [16];

    always @(posedge clk) cyc <= cyc + 1;

    // Team ALU: combinational, same-cycle result.
    always_comb begin
        bus.alu_result = '0;
        case (bus.alu_opcode)
            5'd0: bus.alu_result = bus.alu_operandA + bus.alu_operandB;
            5'd2: bus.alu_result = bus.alu_operandA & bus.alu_operandB;
            5'd5: bus.alu_result = $unsigned($signed(bus.alu_operandA) >>> bus.alu_shiftamt);
            5'd6: bus.alu_result = bus.alu_operandA ^ bus.alu_operandB;
            5'd7: bus.alu_result = (bus.alu_operandA >> bus.alu_shiftamt) |
                                   (bus.alu_operandA << (6'd32 - {1'b0, bus.alu_shiftamt}));
            default: bus.alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic push_block();
        logic [31:0] w [64];
        for (int i = 0; i < 16; i++) w[i] = blk[i];
        for (int i = 16; i < 64; i++) begin
            w[i] = sig1(w[i-2]) + w[i-7] + sig0(w[i-15]) + w[i-16];
            sb.push_back('{idx: 6'(i), w: w[i]});
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    task automatic set_rand();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
    endtask

    task automatic load_block(input bit hold_valid);
        push_block();
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_word  = blk[i];
            @(posedge clk); #1;
        end
        bus.in_word = 32'hDEADBEEF;
        if (!hold_valid) bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!bus.out_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!bus.out_valid) chk("valid_timeout", 64'(bus.out_valid), 64'd1);
    endtask

    task automatic handshake_one();
        wait_valid();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    always @(negedge clk)
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
            else begin
                mon_e = sb.pop_front();
                chk("out_index", 64'(bus.out_index), 64'(mon_e.idx));
                chk("out_word", 64'(bus.out_word), 64'(mon_e.w));
                if (spacing_en && mon_e.idx != 6'd16) chk("spacing", 64'(cyc - last_hs), 64'd16);
                last_hs = cyc;
                dut_w[bus.out_index] = bus.out_word;
            end
        end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold_w;
        logic [5:0]  hold_i;
        int          k;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_word = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_out_word", 64'(bus.out_word), 64'd0);
        chk("rst_out_index", 64'(bus.out_index), 64'd0);
        chk("rst_alu", {27'd0, bus.alu_opcode, bus.alu_operandA}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: "abc" block, free-running output
        spacing_en = 1'b1;
        bus.out_ready = 1'b1;
        set_abc();
        load_block(1'b0);
        drain();
        chk("abc_w16", 64'(dut_w[16]), 64'h61626380);
        chk("abc_w17", 64'(dut_w[17]), 64'h000F0000);
        chk("abc_w18", 64'(dut_w[18]), 64'h7DA86405);
        chk("abc_w19", 64'(dut_w[19]), 64'h600003C6);
        chk("wrap_idle", 64'({bus.in_ready, bus.busy}), 64'b10);

        // 2: all ones exposes sign-extension of the shifts
        for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
        load_block(1'b0);
        drain();
        chk("ones_w16", 64'(dut_w[16]), 64'h203FFFFC);

        // 3: backpressure at t=20
        spacing_en = 1'b0;
        bus.out_ready = 1'b0;
        set_abc();
        load_block(1'b0);
        repeat (4) handshake_one();
        wait_valid();
        chk("stall_index", 64'(bus.out_index), 64'd20);
        hold_w = bus.out_word;
        hold_i = bus.out_index;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_word", 64'(bus.out_word), 64'(hold_w));
            chk("stall_idx", 64'(bus.out_index), 64'(hold_i));
            chk("stall_alu", {27'd0, bus.alu_opcode, bus.alu_operandA | bus.alu_operandB}, 64'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drain();

        // 4: in_valid stuck high outside LOAD
        spacing_en = 1'b1;
        set_abc();
        load_block(1'b1);
        k = 0;
        while (sb.size() > 1 && k < 3000) begin
            @(negedge clk);
            if (bus.out_valid) chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
            k++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        drain();

        // 5: reset at step 7 of t=30
        set_abc();
        load_block(1'b0);
        k = 0;
        while (!(bus.out_valid && bus.out_index == 6'd29) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1;
        repeat (7) @(posedge clk);
        #1;
        chk("step7_op", 64'({bus.alu_opcode, bus.alu_shiftamt}), 64'({5'd7, 5'd19}));
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        chk("abort_alu", 64'(bus.alu_opcode), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_abc();
        load_block(1'b0);
        drain();
        chk("rerun_w19", 64'(dut_w[19]), 64'h600003C6);

        // 6: back-to-back random blocks
        for (int b = 0; b < 2; b++) begin
            set_rand();
            load_block(1'b0);
            drain();
            @(negedge clk);
            chk("b2b_wrap", 64'({bus.in_ready, bus.busy}), 64'b10);
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
